mmio_target: RTL and testbench

- Memory-mapped I/O responder on the core's data-port memory interface; the core initiates, this block responds.
- Decodes a 256-byte window and owns the exit/"done" register at 0x600d600c, an LED register, a console TX byte FIFO and a 64-bit cycle counter.
- Sits beside main memory on the dmem bus; the top level selects which responder's read data returns to the core.

---
 rtl/mmio_target.sv | 152 +++++++++++++++
 tb/tb_mmio_target.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mmio_target.sv
// MMIO responder on the dmem bus: LED, console TX FIFO, exit flag and
// a free-running 64-bit cycle counter in a 256-byte window.
module mmio_target #(
    parameter logic [31:0] BASE_ADDR  = 32'h600d6000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] addr,
    input  logic [31:0] data_i,
    input  logic        data_en,
    input  logic        write_en,
    output logic [31:0] data_o,
    output logic        hit,
    output logic [3:0]  led,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        done,
    output logic [31:0] exit_code
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [5:0] OFF_LED    = 6'h00;
    localparam logic [5:0] OFF_TXDATA = 6'h01;
    localparam logic [5:0] OFF_STATUS = 6'h02;
    localparam logic [5:0] OFF_EXIT   = 6'h03;
    localparam logic [5:0] OFF_CYCLO  = 6'h04;
    localparam logic [5:0] OFF_CYCHI  = 6'h05;

    logic [31:0] data_o_q;
    logic        hit_q;
    logic [3:0]  led_q;
    logic        done_q;
    logic [31:0] exit_code_q;
    logic [63:0] cycle_q;
    logic [31:0] hi_shadow_q;
    logic        ovf_q, ovf_d;
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]  head_q, head_d;
    logic        tx_valid_q;

    logic        sel, wr, rd;
    logic [5:0]  offset;
    logic        push_req, push_ok, pop, full, empty, ovf_set;
    logic [31:0] rdata;
    logic        unused_ok;

    assign offset    = addr[7:2];
    assign sel       = data_en && (addr[31:8] == BASE_ADDR[31:8]);
    assign wr        = sel && write_en;
    assign rd        = sel && !write_en;
    assign unused_ok = ^addr[1:0];

    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign push_req = wr && (offset == OFF_TXDATA);
    assign pop      = tx_valid_q && tx_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
    assign push_ok  = push_req && (!full || pop);
    assign ovf_set  = push_req && full && !pop;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_ok) wptr_d = wptr_q + 1'b1;
        if (pop) rptr_d = rptr_q + 1'b1;
        count_d = count_q + CW'(push_ok) - CW'(pop);
    end

    // Next head: a byte written this cycle may become the head immediately.
    always_comb begin
        head_d = 8'h00;
        if (count_d != '0) begin
            if (push_ok && (wptr_q == rptr_d)) head_d = data_i[7:0];
            else head_d = mem_q[rptr_d];
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (rd && (offset == OFF_STATUS)) ovf_d = 1'b0;
        if (ovf_set) ovf_d = 1'b1;
    end

    always_comb begin
        rdata = 32'h0;
        if (rd) begin
            case (offset)
                OFF_LED:    rdata = {28'h0, led_q};
                OFF_STATUS: rdata = {16'h0, 8'(count_q), 5'h0, ovf_q, full, empty};
                OFF_EXIT:   rdata = exit_code_q;
                OFF_CYCLO:  rdata = cycle_q[31:0];
                OFF_CYCHI:  rdata = hi_shadow_q;
                default:    rdata = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= data_i[7:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_o_q    <= 32'h0;
            hit_q       <= 1'b0;
            led_q       <= 4'h0;
            done_q      <= 1'b0;
            exit_code_q <= 32'h0;
            cycle_q     <= 64'h0;
            hi_shadow_q <= 32'h0;
            ovf_q       <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            head_q      <= 8'h00;
            tx_valid_q  <= 1'b0;
        end else begin
            data_o_q   <= rdata;
            hit_q      <= sel;
            cycle_q    <= cycle_q + 64'h1;
            ovf_q      <= ovf_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tx_valid_q <= (count_d != '0);
            if (wr && (offset == OFF_LED)) led_q <= data_i[3:0];
            if (wr && (offset == OFF_EXIT) && !done_q) begin
                done_q      <= 1'b1;
                exit_code_q <= data_i;
            end
            if (rd && (offset == OFF_CYCLO)) hi_shadow_q <= cycle_q[63:32];
        end
    end

    assign data_o    = data_o_q;
    assign hit       = hit_q;
    assign led       = led_q;
    assign tx_data   = head_q;
    assign tx_valid  = tx_valid_q;
    assign done      = done_q;
    assign exit_code = exit_code_q;

endmodule

// File: tb/tb_mmio_target.sv
// Scoreboard bench for mmio_target: response queue plus TX byte queue,
// each drained by its own monitor process.
module tb_mmio_target;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] addr;
    logic [31:0] data_i;
    logic        data_en;
    logic        write_en;
    logic [31:0] data_o;
    logic        hit;
    logic [3:0]  led;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        done;
    logic [31:0] exit_code;

    localparam logic [31:0] B = 32'h600d6000;

    logic [32:0] exp_q[$];
    logic [7:0]  tx_exp_q[$];
    int n_run  = 0;
    int n_fail = 0;

    mmio_target dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .addr      (addr),
        .data_i    (data_i),
        .data_en   (data_en),
        .write_en  (write_en),
        .data_o    (data_o),
        .hit       (hit),
        .led       (led),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .done      (done),
        .exit_code (exit_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req_v);
        n_run++;
        if (act !== req_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req_v);
        end
    endtask

    task automatic req(input logic en, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic h, input logic [31:0] rv);
        @(posedge clk);
        #2;
        data_en  = en;
        write_en = we;
        addr     = a;
        data_i   = d;
        exp_q.push_back({h, rv});
    endtask

    task automatic idle();
        req(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    // Response monitor: registered outputs just after the edge.
    always @(posedge clk) begin
        #1;
        if (reset_n && exp_q.size() > 0) begin
            check("resp", 64'({hit, data_o}), 64'(exp_q[0]));
            void'(exp_q.pop_front());
        end
    end

    // TX monitor: mid-cycle, what the next edge will consume.
    always @(negedge clk) begin
        if (reset_n && tx_valid) begin
            if (tx_exp_q.size() == 0) begin
                n_run++;
                n_fail++;
                $display("FAIL tx_extra: got %h expected none", tx_data);
            end else begin
                check("tx_data", 64'(tx_data), 64'(tx_exp_q[0]));
                if (tx_ready) void'(tx_exp_q.pop_front());
            end
        end
    end

    initial begin
        reset_n  = 1'b0;
        data_en  = 1'b0;
        write_en = 1'b0;
        addr     = 32'h0;
        data_i   = 32'h0;
        tx_ready = 1'b0;
        #12;
        check("rst_data_o", 64'(data_o), 64'h0);
        check("rst_hit", 64'(hit), 64'h0);
        check("rst_led", 64'(led), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        check("rst_exit", 64'(exit_code), 64'h0);
        check("rst_tx_valid", 64'(tx_valid), 64'h0);
        check("rst_tx_data", 64'(tx_data), 64'h0);
        #10;
        reset_n = 1'b1;

        req(1, 1, B, 32'hA5, 1, 32'h0);
        req(1, 0, B, 32'h0, 1, 32'h5);
        check("led", 64'(led), 64'h5);

        for (int i = 0; i < 8; i++) begin
            req(1, 1, B + 32'h4, 32'h41 + i, 1, 32'h0);
            tx_exp_q.push_back(8'(8'h41 + i));
        end
        req(1, 0, B + 32'h8, 32'h0, 1, 32'h0000_0802);
        req(1, 1, B + 32'h4, 32'h49, 1, 32'h0);
        req(1, 0, B + 32'h8, 32'h0, 1, 32'h0000_0806);
        req(1, 0, B + 32'h8, 32'h0, 1, 32'h0000_0802);

        req(1, 1, B + 32'h4, 32'h50, 1, 32'h0);
        tx_ready = 1'b1;
        tx_exp_q.push_back(8'h50);
        req(1, 0, B + 32'h8, 32'h0, 1, 32'h0000_0802);
        tx_ready = 1'b0;
        idle();
        tx_ready = 1'b1;
        repeat (9) idle();
        check("tx_drained_valid", 64'(tx_valid), 64'h0);
        check("tx_drained_left", 64'(tx_exp_q.size()), 64'h0);
        req(1, 0, B + 32'h8, 32'h0, 1, 32'h0000_0001);

        req(1, 1, B + 32'hC, 32'h2A, 1, 32'h0);
        req(1, 0, B + 32'hC, 32'h0, 1, 32'h2A);
        check("done", 64'(done), 64'h1);
        check("exit_code", 64'(exit_code), 64'h2A);
        req(1, 1, B + 32'hC, 32'h7, 1, 32'h0);
        req(1, 0, B + 32'hC, 32'h0, 1, 32'h2A);
        check("exit_sticky", 64'(exit_code), 64'h2A);

        dut.cycle_q = 64'h0000_0000_FFFF_FFFD;
        req(1, 0, B + 32'h10, 32'h0, 1, 32'hFFFF_FFFE);
        repeat (5) idle();
        req(1, 0, B + 32'h14, 32'h0, 1, 32'h0);
        req(1, 0, B + 32'h10, 32'h0, 1, 32'h0000_0005);
        req(1, 0, B + 32'h14, 32'h0, 1, 32'h0000_0001);
        dut.cycle_q = 64'hFFFF_FFFF_FFFF_FFFD;
        req(1, 0, B + 32'h10, 32'h0, 1, 32'hFFFF_FFFE);
        req(1, 0, B + 32'h14, 32'h0, 1, 32'hFFFF_FFFF);
        req(1, 0, B + 32'h10, 32'h0, 1, 32'h0);
        req(1, 0, B + 32'h14, 32'h0, 1, 32'h0);

        req(1, 1, 32'h600d7004, 32'h77, 0, 32'h0);
        req(1, 1, B + 32'h20, 32'h77, 1, 32'h0);
        req(0, 1, B, 32'hF, 0, 32'h0);
        req(1, 0, B + 32'h8, 32'h0, 1, 32'h0000_0001);
        req(1, 0, B, 32'h0, 1, 32'h5);
        req(1, 0, B + 32'h20, 32'h0, 1, 32'h0);
        req(1, 0, B + 32'h4, 32'h0, 1, 32'h0);
        tx_ready = 1'b0;

        for (int i = 0; i < 3; i++) begin
            req(1, 1, B + 32'h4, 32'h61 + i, 1, 32'h0);
            tx_exp_q.push_back(8'(8'h61 + i));
        end
        idle();
        tx_ready = 1'b1;
        idle();
        #1;
        reset_n = 1'b0;
        exp_q.delete();
        tx_exp_q.delete();
        #1;
        check("mid_rst_tx_valid", 64'(tx_valid), 64'h0);
        check("mid_rst_done", 64'(done), 64'h0);
        check("mid_rst_exit", 64'(exit_code), 64'h0);
        check("mid_rst_led", 64'(led), 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        req(1, 0, B + 32'h8, 32'h0, 1, 32'h0000_0001);
        req(1, 0, B + 32'hC, 32'h0, 1, 32'h0);
        idle();
        @(posedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
